bus_scheduler: RTL and testbench

- Time-slot scheduler for the shared system bus/RAM. It divides each 16-cycle frame of clk_16_i into a 1 MHz CPU clock, a CPU bus phase and DMA slots.
- DMA slots are arbitrated between the SPI bridge (RPi) and a video fetch requester.
- It drives the per-slot owner, enable and write-window signals from which top-level RAM/IO strobes and bus output-enables are decoded.

---
 rtl/bus_scheduler_pkg.sv | 20 ++
 rtl/bus_scheduler_if.sv | 27 ++
 rtl/bus_scheduler_slot_arbiter.sv | 58 +++++
 rtl/bus_scheduler.sv | 89 ++++++++
 tb/tb_bus_scheduler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_scheduler_pkg.sv
// Shared owner encoding and frame timing constants for the bus/RAM time-slot scheduler.
package bus_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_CPU   = 2'd1,
    OWNER_SPI   = 2'd2,
    OWNER_VIDEO = 2'd3
  } owner_t;

  localparam int FRAME_CYCLES    = 16;
  localparam int CPU_PHASE_START = 8;
  localparam int CPU_WR_FIRST    = 12;
  localparam int CPU_WR_LAST     = 14;

  function automatic logic in_range(input logic [3:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/bus_scheduler_if.sv
// Requester/strobe bundle between bus_scheduler (slave) and the top-level decode (master).
interface bus_scheduler_if;
  logic       cpu_valid_i;
  logic       spi_valid_i;
  logic       spi_rw_ni;
  logic       spi_done_o;
  logic       video_req_i;
  logic       video_ack_o;
  logic       clk_cpu_o;
  logic       cpu_en_o;
  logic       spi_en_o;
  logic       video_en_o;
  logic       wr_window_o;
  logic [3:0] frame_cycle_o;

  modport slave (
    input  cpu_valid_i, spi_valid_i, spi_rw_ni, video_req_i,
    output spi_done_o, video_ack_o, clk_cpu_o, cpu_en_o, spi_en_o, video_en_o,
           wr_window_o, frame_cycle_o
  );

  modport master (
    output cpu_valid_i, spi_valid_i, spi_rw_ni, video_req_i,
    input  spi_done_o, video_ack_o, clk_cpu_o, cpu_en_o, spi_en_o, video_en_o,
           wr_window_o, frame_cycle_o
  );
endinterface

// File: rtl/bus_scheduler_slot_arbiter.sv
// Two-requester (SPI/video) round-robin for DMA slots: registered owner, latched SPI
// direction, and the SPI re-arm latch that stops a held request being served twice.
module slot_arbiter
  import bus_pkg::*;
(
  input  logic   gclk,
  input  logic   grst_n,
  input  logic   i_eval,
  input  logic   i_avail,
  input  logic   i_spi_valid,
  input  logic   i_spi_rw_n,
  input  logic   i_video_req,
  input  logic   i_spi_done,
  output owner_t o_owner,
  output logic   o_rw_n
);

  owner_t r_owner;
  logic   r_ptr_video;
  logic   r_armed;
  logic   r_rw_n;
  logic   w_spi_elig;
  logic   w_video_elig;
  owner_t w_grant;

  assign w_spi_elig   = i_avail && i_spi_valid && r_armed;
  assign w_video_elig = i_avail && i_video_req;

  always_comb begin
    w_grant = OWNER_NONE;
    if (w_spi_elig && w_video_elig) w_grant = r_ptr_video ? OWNER_VIDEO : OWNER_SPI;
    else if (w_spi_elig)            w_grant = OWNER_SPI;
    else if (w_video_elig)          w_grant = OWNER_VIDEO;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_owner     <= OWNER_NONE;
      r_ptr_video <= 1'b0;
      r_armed     <= 1'b1;
      r_rw_n      <= 1'b1;
    end else begin
      if (i_eval) begin
        r_owner <= w_grant;
        if (w_grant == OWNER_SPI) r_rw_n <= i_spi_rw_n;
        if (w_spi_elig && w_video_elig) r_ptr_video <= ~r_ptr_video;
      end
      // A low sample means the bridge has retired the command, so it may re-arm
      // even on the completion cycle itself.
      if (!i_spi_valid)    r_armed <= 1'b1;
      else if (i_spi_done) r_armed <= 1'b0;
    end
  end

  assign o_owner = r_owner;
  assign o_rw_n  = r_rw_n;

endmodule

// File: rtl/bus_scheduler.sv
// 16-cycle frame scheduler: CPU phi2/phase, DMA slot grants and write windows.
// Video participation is enabled by defining BUS_SCHEDULER_VIDEO_FETCH_EN.
module bus_scheduler
  import bus_pkg::*;
#(
  parameter int SLOT_CYCLES = 4,
  parameter int WR_START    = 1,
  parameter int WR_LEN      = 2
) (
  input  logic            clk_16_i,
  input  logic            reset_ni,
  bus_scheduler_if.slave  bus
);

  logic [3:0] r_cnt;
  logic       r_cpu_phase;
  logic [3:0] w_off;
  logic       w_first;
  logic       w_last;
  logic       w_in_wr;
  logic       w_clk_cpu;
  logic       w_cpu_en;
  logic       w_avail;
  logic       w_video_req;
  owner_t     w_owner;
  logic       w_rw_n;
  logic       w_spi_en;
  logic       w_spi_done;

  assign w_off     = r_cnt & 4'(SLOT_CYCLES - 1);
  assign w_first   = (w_off == 4'd0);
  assign w_last    = (w_off == 4'(SLOT_CYCLES - 1));
  assign w_in_wr   = in_range(w_off, WR_START, WR_START + WR_LEN - 1);
  assign w_clk_cpu = (r_cnt >= 4'(CPU_PHASE_START));
  assign w_cpu_en  = r_cpu_phase && w_clk_cpu;
  // Slots A/B are always DMA; C/D only when the CPU phase was declined at cycle 7.
  assign w_avail   = !w_cpu_en;

  always_ff @(posedge clk_16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt       <= 4'd0;
      r_cpu_phase <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'(CPU_PHASE_START - 1)) r_cpu_phase <= bus.cpu_valid_i;
    end
  end

`ifdef BUS_SCHEDULER_VIDEO_FETCH_EN
  assign w_video_req = bus.video_req_i;
`else
  assign w_video_req = 1'b0;
`endif

  slot_arbiter u_arb (
    .gclk        (clk_16_i),
    .grst_n      (reset_ni),
    .i_eval      (w_first),
    .i_avail     (w_avail),
    .i_spi_valid (bus.spi_valid_i),
    .i_spi_rw_n  (bus.spi_rw_ni),
    .i_video_req (w_video_req),
    .i_spi_done  (w_spi_done),
    .o_owner     (w_owner),
    .o_rw_n      (w_rw_n)
  );

  // The registered owner lingers into the next slot's first cycle; mask it when
  // that cycle opens the CPU phase so only one requester ever drives the bus.
  assign w_spi_en   = (w_owner == OWNER_SPI) && !w_cpu_en;
  assign w_spi_done = (w_owner == OWNER_SPI) && w_last;

  assign bus.clk_cpu_o     = w_clk_cpu;
  assign bus.cpu_en_o      = w_cpu_en;
  assign bus.spi_en_o      = w_spi_en;
  assign bus.spi_done_o    = w_spi_done;
  assign bus.frame_cycle_o = r_cnt;
  assign bus.wr_window_o   = (w_cpu_en && in_range(r_cnt, CPU_WR_FIRST, CPU_WR_LAST)) ||
                             (w_spi_en && !w_rw_n && w_in_wr);

`ifdef BUS_SCHEDULER_VIDEO_FETCH_EN
  assign bus.video_en_o  = (w_owner == OWNER_VIDEO) && !w_cpu_en;
  assign bus.video_ack_o = (w_owner == OWNER_VIDEO) && w_last;
`else
  assign bus.video_en_o  = 1'b0;
  assign bus.video_ack_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed + randomized bench for bus_scheduler against a per-cycle reference model.
module tb_bus_scheduler;

  logic clk_16 = 1'b0;
  logic reset_n;

  bus_scheduler_if bif();

  bus_scheduler #(.SLOT_CYCLES(4), .WR_START(1), .WR_LEN(2)) dut (
    .clk_16_i (clk_16),
    .reset_ni (reset_n),
    .bus      (bif)
  );

  always #5 clk_16 = ~clk_16;

`ifdef BUS_SCHEDULER_VIDEO_FETCH_EN
  localparam bit VID = 1'b1;
`else
  localparam bit VID = 1'b0;
`endif

  localparam int O_NONE = 0, O_SPI = 1, O_VID = 2;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_fc;
  bit m_phase;
  int m_owner;
  bit m_armed;
  bit m_ptr_vid;
  bit m_rw;

  int n_done, n_ack, n_spi, n_cpu, n_clk, n_wr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_counts();
    n_done = 0; n_ack = 0; n_spi = 0; n_cpu = 0; n_clk = 0; n_wr = 0;
  endtask

  task automatic model_reset();
    m_fc = 0; m_phase = 0; m_owner = O_NONE; m_armed = 1; m_ptr_vid = 0; m_rw = 1;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int off, slot;
    bit done_now, dma, es, ev;
    off      = m_fc % 4;
    slot     = m_fc / 4;
    done_now = (m_owner == O_SPI) && (off == 3);
    if (off == 0) begin
      dma = (slot < 2) || !m_phase;
      es  = dma && bif.spi_valid_i && m_armed;
      ev  = dma && VID && bif.video_req_i;
      if (es && ev) begin
        m_owner   = m_ptr_vid ? O_VID : O_SPI;
        m_ptr_vid = !m_ptr_vid;
      end else if (es) m_owner = O_SPI;
      else if (ev)     m_owner = O_VID;
      else             m_owner = O_NONE;
      if (m_owner == O_SPI) m_rw = bif.spi_rw_ni;
    end
    if (!bif.spi_valid_i) m_armed = 1;
    else if (done_now)    m_armed = 0;
    if (m_fc == 7) m_phase = bif.cpu_valid_i;
    m_fc = (m_fc + 1) % 16;
  endtask

  task automatic check_outputs();
    int off;
    bit e_clk, e_cpu, e_spi, e_vid, e_wr, e_done, e_ack;
    off    = m_fc % 4;
    e_clk  = (m_fc >= 8);
    e_cpu  = m_phase && e_clk;
    e_spi  = (m_owner == O_SPI) && !e_cpu;
    e_vid  = (m_owner == O_VID) && !e_cpu;
    e_wr   = (e_cpu && m_fc >= 12 && m_fc <= 14) || (e_spi && !m_rw && off >= 1 && off <= 2);
    e_done = (m_owner == O_SPI) && (off == 3);
    e_ack  = (m_owner == O_VID) && (off == 3);
    chk("frame_cycle", 32'(bif.frame_cycle_o), 32'(m_fc));
    chk("clk_cpu",     32'(bif.clk_cpu_o),     32'(e_clk));
    chk("cpu_en",      32'(bif.cpu_en_o),      32'(e_cpu));
    chk("spi_en",      32'(bif.spi_en_o),      32'(e_spi));
    chk("video_en",    32'(bif.video_en_o),    32'(e_vid));
    chk("wr_window",   32'(bif.wr_window_o),   32'(e_wr));
    chk("spi_done",    32'(bif.spi_done_o),    32'(e_done));
    chk("video_ack",   32'(bif.video_ack_o),   32'(e_ack));
    chk("onehot_en", 32'($countones({bif.cpu_en_o, bif.spi_en_o, bif.video_en_o}) <= 1), 32'd1);
    if (bif.spi_done_o === 1'b1)  n_done++;
    if (bif.video_ack_o === 1'b1) n_ack++;
    if (bif.spi_en_o === 1'b1)    n_spi++;
    if (bif.cpu_en_o === 1'b1)    n_cpu++;
    if (bif.clk_cpu_o === 1'b1)   n_clk++;
    if (bif.wr_window_o === 1'b1) n_wr++;
  endtask

  task automatic tick();
    @(posedge clk_16);
    if (reset_n) model_step();
    @(negedge clk_16);
    check_outputs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_frame",   32'(bif.frame_cycle_o), 32'd0);
    chk("rst_clk_cpu", 32'(bif.clk_cpu_o),     32'd0);
    chk("rst_cpu_en",  32'(bif.cpu_en_o),      32'd0);
    chk("rst_spi_en",  32'(bif.spi_en_o),      32'd0);
    chk("rst_vid_en",  32'(bif.video_en_o),    32'd0);
    chk("rst_wr",      32'(bif.wr_window_o),   32'd0);
    chk("rst_done",    32'(bif.spi_done_o),    32'd0);
    chk("rst_ack",     32'(bif.video_ack_o),   32'd0);
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b1;
    bif.cpu_valid_i = 1'b0;
    bif.spi_valid_i = 1'b0;
    bif.spi_rw_ni   = 1'b1;
    bif.video_req_i = 1'b0;
    #2;

    // CPU running, no DMA requests
    bif.cpu_valid_i = 1'b1;
    do_reset();
    clr_counts();
    repeat (40) tick();
    chk("t1_clk_cycles", n_clk, 17);
    chk("t1_cpu_cycles", n_cpu, 17);
    chk("t1_spi_cycles", n_spi, 0);

    // held SPI write: served once, then again only after a low/high cycle
    bif.spi_valid_i = 1'b1;
    bif.spi_rw_ni   = 1'b0;
    do_reset();
    clr_counts();
    repeat (40) tick();
    chk("t2_done_once", n_done, 1);
    chk("t2_spi_cycles", n_spi, 4);
    chk("t2_wr_cycles", n_wr, 8);
    bif.spi_valid_i = 1'b0;
    tick();
    bif.spi_valid_i = 1'b1;
    repeat (48) tick();
    chk("t2_done_rearm", n_done, 2);

    // CPU halted: all four slots go to SPI, phi2 keeps toggling
    bif.cpu_valid_i = 1'b0;
    bif.spi_valid_i = 1'b1;
    bif.spi_rw_ni   = 1'b1;
    do_reset();
    clr_counts();
    repeat (48) begin
      tick();
      bif.spi_valid_i = !bif.spi_done_o;
    end
    chk("t3_done_all_slots", n_done, 12);
    chk("t3_cpu_cycles", n_cpu, 0);
    chk("t3_clk_cycles", n_clk, 24);

    // reset in the middle of an SPI write slot
    bif.cpu_valid_i = 1'b1;
    bif.spi_valid_i = 1'b1;
    bif.spi_rw_ni   = 1'b0;
    do_reset();
    tick();
    tick();
    chk("t4_wr_before_rst", 32'(bif.wr_window_o), 32'd1);
    do_reset();
    clr_counts();
    repeat (8) tick();
    chk("t4_done_after_rst", n_done, 1);

    // SPI and video both requesting, CPU running
    bif.video_req_i = 1'b1;
    bif.spi_rw_ni   = 1'b1;
    do_reset();
    clr_counts();
    repeat (64) begin
      tick();
      bif.spi_valid_i = !bif.spi_done_o;
    end
    chk("t5_spi_done", n_done, VID ? 4 : 8);
    chk("t5_video_ack", n_ack, VID ? 4 : 0);

    // randomized traffic with occasional resets
    do_reset();
    repeat (800) begin
      tick();
      if (bif.spi_done_o && $urandom_range(0, 1) == 1) bif.spi_valid_i = 1'b0;
      else if ($urandom_range(0, 5) == 0)               bif.spi_valid_i = !bif.spi_valid_i;
      bif.spi_rw_ni   = 1'($urandom_range(0, 1));
      bif.cpu_valid_i = ($urandom_range(0, 3) != 0);
      bif.video_req_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 249) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
